gpio_port_bank: RTL and testbench
=================================

# gpio_port_bank

Parametrised memory-mapped GPIO port bank. It extends the single fixed 32-bit output latch into a full port with per-pin direction, set/clear/toggle writes, synchronised input read-back and rising-edge interrupts. It sits on the core's data-memory bus beside RAM. It is selected when the bus address falls inside its 32-byte window at BASE_ADDR.

## Interface

- WIDTH, 32: number of GPIO pins, 1..32.
- BASE_ADDR, 32'h0000ABC0: window base, 32-byte aligned (bits [4:0] must be 0).

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- addr  in  32  byte address from the bus.
- wdata  in  32  write data.
- we  in  1  write strobe, one cycle per write.
- re  in  1  read strobe, one cycle per read.
- rdata  out  32  registered read data.
- rvalid  out  1  one-cycle pulse; rdata is valid while high.
- pins_in  in  WIDTH  asynchronous pad inputs.
- pins_out  out  WIDTH  output register value.
- pins_oe  out  WIDTH  direction register (1 = drive).
- irq  out  1  interrupt request, level.

## Operation

- Address select: hit = (addr[31:5] == BASE_ADDR[31:5]). The offset is addr[4:0]. Ignore we and re on a miss.
- Register map (offset: name, access):
  - 0x00 OUT, R/W.
  - 0x04 DIR, R/W.
  - 0x08 IN, RO: the synchronised pins.
  - 0x0C IEN, R/W: per-pin rising-edge interrupt enable.
  - 0x10 PEND, R/W1C: pending flags.
  - 0x14 OUT_SET, WO: OUT |= wdata.
  - 0x18 OUT_CLR, WO: OUT &= ~wdata.
  - 0x1C OUT_TGL, WO: OUT ^= wdata.
- Write-only offsets read 0. Writes to IN are ignored.
- Only wdata[WIDTH-1:0] is used. Register bits above WIDTH-1 read 0.
- pins_out = OUT and pins_oe = DIR, driven directly from the registers.
- Input path is three flops per pin: s1 <= pins_in, s2 <= s1, s3 <= s2. IN reads s2.
- Edge event per pin: rise = s2 & ~s3 & IEN.
- PEND update each cycle: PEND <= (PEND & ~w1c_mask) | rise.
  - w1c_mask = wdata on a write hit to 0x10, otherwise 0.
  - A new rise on the same cycle as a W1C of that bit leaves the bit set (set wins).
- Clearing an IEN bit does not clear that bit's PEND flag.
- irq = |(PEND & IEN), combinational from registers.
- Read: on a re hit, rdata <= selected register and rvalid <= 1 on the next edge. Otherwise rvalid <= 0 and rdata holds its last value.
- If we and re hit the same register in the same cycle, the read returns the pre-write value.

## Timing

- Reset (asynchronous, immediate) clears to 0:
  - OUT, DIR, IEN, PEND;
  - s1, s2, s3;
  - rdata, rvalid.
  - Therefore pins_out = 0, pins_oe = 0, irq = 0.
- Release reset synchronously to clock at system level. Within the block, release is clean because all flops reset to 0.
- Write latency: a register is updated on the same clock edge that samples we. pins_out and pins_oe change right after that edge.
- Read latency: one cycle, from the re edge to rvalid/rdata.
- Input latency: a pin stable before edge N is visible in IN after edge N+1.
- Interrupt latency: with IEN set, a 0→1 pin change stable before edge N sets PEND at edge N+2. irq rises after edge N+2.
- Glitches shorter than one clock period may be missed. This is not an error.
- Back-to-back accesses are allowed every cycle with no stall.
- Reset asserted mid-read: the rvalid pulse is cancelled.

## Test plan

WIDTH=8, BASE_ADDR=32'h0000ABC0 for all scenarios.

- Reset: assert reset asynchronously mid-cycle after writing OUT=0xFF → pins_out, pins_oe, irq and rvalid go to 0 immediately, without waiting for a clock edge.
- Set/clear/toggle: write OUT=0x0F, OUT_SET=0x30, OUT_CLR=0x03, OUT_TGL=0x81, then read OUT → pins_out is 0x0F, 0x3F, 0x3C, 0xBD after each write. Read returns 0x000000BD with rvalid one cycle after re.
- Decode and width: write 0xFFFFFFFF to 0x0000ABC4 → DIR reads 0x000000FF. Write 0x55 to 0x0000ABE0 (miss) → no register changes and rvalid stays 0 on a read there.
- Input sync: drive pins_in=0xA5 before edge N → an IN read issued at edge N+2 returns 0x000000A5.
- Interrupt: set IEN=0x01 and raise pins_in[0] before edge N → irq=1 after edge N+2 and PEND reads 0x01. Raising pins_in[1] (not enabled) leaves PEND=0x01. W1C 0x01 → irq=0 next cycle.
- Simultaneous set/W1C: W1C PEND bit 0 in the exact cycle a new rise on pin 0 is detected → PEND[0] stays 1 and irq stays 1.

Source files
------------

// File: rtl/gpio_port_bank.sv
// Memory-mapped GPIO port bank: per-pin direction, set/clear/toggle writes,
// three-flop synchronised inputs and rising-edge interrupts with W1C pending flags.
module gpio_port_bank #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000ABC0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  input  logic             re,
  output logic [31:0]      rdata,
  output logic             rvalid,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] pins_out,
  output logic [WIDTH-1:0] pins_oe,
  output logic             irq
);

  localparam logic [4:0] OFF_OUT  = 5'h00;
  localparam logic [4:0] OFF_DIR  = 5'h04;
  localparam logic [4:0] OFF_IN   = 5'h08;
  localparam logic [4:0] OFF_IEN  = 5'h0C;
  localparam logic [4:0] OFF_PEND = 5'h10;
  localparam logic [4:0] OFF_SET  = 5'h14;
  localparam logic [4:0] OFF_CLR  = 5'h18;
  localparam logic [4:0] OFF_TGL  = 5'h1C;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] s3_q, s3_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic             hit;
  logic [4:0]       offset;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] rise;
  logic [31:0]      rd_val;
  logic             unused_wdata;

  assign hit          = (addr[31:5] == BASE_ADDR[31:5]);
  assign offset       = addr[4:0];
  assign wd           = wdata[WIDTH-1:0];
  assign unused_wdata = ^wdata;

  // Read mux uses pre-write register values, so a same-cycle write is not visible.
  always_comb begin
    rd_val = '0;
    case (offset)
      OFF_OUT:  rd_val[WIDTH-1:0] = out_q;
      OFF_DIR:  rd_val[WIDTH-1:0] = dir_q;
      OFF_IN:   rd_val[WIDTH-1:0] = s2_q;
      OFF_IEN:  rd_val[WIDTH-1:0] = ien_q;
      OFF_PEND: rd_val[WIDTH-1:0] = pend_q;
      default:  rd_val = '0;
    endcase
  end

  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    ien_d    = ien_q;
    w1c_mask = '0;
    if (hit && we) begin
      case (offset)
        OFF_OUT:  out_d    = wd;
        OFF_DIR:  dir_d    = wd;
        OFF_IEN:  ien_d    = wd;
        OFF_PEND: w1c_mask = wd;
        OFF_SET:  out_d    = out_q | wd;
        OFF_CLR:  out_d    = out_q & ~wd;
        OFF_TGL:  out_d    = out_q ^ wd;
        default:  ;
      endcase
    end

    s1_d = pins_in;
    s2_d = s1_q;
    s3_d = s2_q;

    // A fresh rise is ORed in after the clear, so it survives a same-cycle W1C.
    rise   = s2_q & ~s3_q & ien_q;
    pend_d = (pend_q & ~w1c_mask) | rise;

    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (hit && re) begin
      rdata_d  = rd_val;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q    <= '0;
      dir_q    <= '0;
      ien_q    <= '0;
      pend_q   <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      ien_q    <= ien_d;
      pend_q   <= pend_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign pins_out = out_q;
  assign pins_oe  = dir_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign irq      = |(pend_q & ien_q);

endmodule

// File: tb/tb_gpio_port_bank.sv
// Self-checking bench for gpio_port_bank (WIDTH=8): vector table plus hand-written
// reset, input-sync and interrupt sequences; read data checked through a scoreboard queue.
module tb_gpio_port_bank;

  localparam int          W    = 8;
  localparam logic [31:0] BASE = 32'h0000ABC0;

  localparam logic [31:0] A_OUT  = BASE + 32'h00;
  localparam logic [31:0] A_DIR  = BASE + 32'h04;
  localparam logic [31:0] A_IN   = BASE + 32'h08;
  localparam logic [31:0] A_IEN  = BASE + 32'h0C;
  localparam logic [31:0] A_PEND = BASE + 32'h10;
  localparam logic [31:0] A_SET  = BASE + 32'h14;
  localparam logic [31:0] A_CLR  = BASE + 32'h18;
  localparam logic [31:0] A_TGL  = BASE + 32'h1C;
  localparam logic [31:0] A_MISS = 32'h0000ABE0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   addr  = '0;
  logic [31:0]   wdata = '0;
  logic          we    = 1'b0;
  logic          re    = 1'b0;
  logic [31:0]   rdata;
  logic          rvalid;
  logic [W-1:0]  pins_in = '0;
  logic [W-1:0]  pins_out;
  logic [W-1:0]  pins_oe;
  logic          irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  gpio_port_bank #(.WIDTH(W), .BASE_ADDR(BASE)) dut (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .pins_in  (pins_in),
    .pins_out (pins_out),
    .pins_oe  (pins_oe),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         we;
    logic         re;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_oe;
    logic         exp_rv;
    logic [31:0]  exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one bus cycle, lets the DUT sample it, then returns 1 ns after that edge.
  task automatic bus(input logic w, input logic r, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_rv);
    @(negedge clock);
    we = w; re = r; addr = a; wdata = d;
    if (r && exp_rv) exp_q.push_back(exp_rd);
    @(posedge clock);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, a, d, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_rd);
    bus(1'b0, 1'b1, a, 32'h0, exp_rd, 1'b1);
    chk("read_rvalid", {31'b0, rvalid}, 32'h1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Scoreboard: every rvalid pulse consumes one expected read value.
  always @(posedge clock) begin
    #1;
    if (rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h expected no read", rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL read_data: got %h expected %h", rdata, e);
        end
      end
    end
  end

  function automatic vec_t mk(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input logic [W-1:0] eo,
                              input logic [W-1:0] eoe, input logic erv,
                              input logic [31:0] erd);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.wdata = d;
    v.exp_out = eo; v.exp_oe = eoe; v.exp_rv = erv; v.exp_rdata = erd;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk(1, 0, A_OUT,  32'h0000000F, 8'h0F, 8'h00, 0, 32'h0));
    vecs.push_back(mk(1, 0, A_SET,  32'h00000030, 8'h3F, 8'h00, 0, 32'h0));
    vecs.push_back(mk(1, 0, A_CLR,  32'h00000003, 8'h3C, 8'h00, 0, 32'h0));
    vecs.push_back(mk(1, 0, A_TGL,  32'h00000081, 8'hBD, 8'h00, 0, 32'h0));
    vecs.push_back(mk(0, 1, A_OUT,  32'h0,        8'hBD, 8'h00, 1, 32'h000000BD));
    vecs.push_back(mk(1, 0, A_DIR,  32'hFFFFFFFF, 8'hBD, 8'hFF, 0, 32'h0));
    vecs.push_back(mk(0, 1, A_DIR,  32'h0,        8'hBD, 8'hFF, 1, 32'h000000FF));
    vecs.push_back(mk(1, 0, A_MISS, 32'h00000055, 8'hBD, 8'hFF, 0, 32'h0));
    vecs.push_back(mk(0, 1, A_MISS, 32'h0,        8'hBD, 8'hFF, 0, 32'h0));
    vecs.push_back(mk(0, 1, A_SET,  32'h0,        8'hBD, 8'hFF, 1, 32'h0));
    vecs.push_back(mk(1, 0, A_IN,   32'h00000012, 8'hBD, 8'hFF, 0, 32'h0));
    vecs.push_back(mk(0, 1, A_IN,   32'h0,        8'hBD, 8'hFF, 1, 32'h0));
    vecs.push_back(mk(1, 1, A_OUT,  32'h00000011, 8'h11, 8'hFF, 1, 32'h000000BD));
    vecs.push_back(mk(0, 1, A_IEN,  32'h0,        8'h11, 8'hFF, 1, 32'h0));
    vecs.push_back(mk(0, 1, A_PEND, 32'h0,        8'h11, 8'hFF, 1, 32'h0));
    vecs.push_back(mk(1, 0, A_TGL,  32'hFFFFFF00, 8'h11, 8'hFF, 0, 32'h0));

    // Reset state
    idle(2);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("reset_pins_out", {24'b0, pins_out}, 32'h0);
    chk("reset_pins_oe",  {24'b0, pins_oe},  32'h0);
    chk("reset_irq",      {31'b0, irq},      32'h0);
    chk("reset_rvalid",   {31'b0, rvalid},   32'h0);

    // Table-driven register accesses
    for (int i = 0; i < vecs.size(); i++) begin
      bus(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_rv);
      chk($sformatf("vec%0d_pins_out", i), {24'b0, pins_out}, {24'b0, vecs[i].exp_out});
      chk($sformatf("vec%0d_pins_oe", i),  {24'b0, pins_oe},  {24'b0, vecs[i].exp_oe});
      chk($sformatf("vec%0d_rvalid", i),   {31'b0, rvalid},   {31'b0, vecs[i].exp_rv});
    end

    // Asynchronous reset mid-cycle, cancelling a live rvalid pulse
    wr(A_OUT, 32'h000000FF);
    chk("pre_reset_out", {24'b0, pins_out}, 32'h000000FF);
    bus(1'b0, 1'b1, A_OUT, 32'h0, 32'h000000FF, 1'b1);
    chk("pre_reset_rvalid", {31'b0, rvalid}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_pins_out", {24'b0, pins_out}, 32'h0);
    chk("async_reset_pins_oe",  {24'b0, pins_oe},  32'h0);
    chk("async_reset_irq",      {31'b0, irq},      32'h0);
    chk("async_reset_rvalid",   {31'b0, rvalid},   32'h0);
    @(negedge clock);
    reset = 1'b0;
    idle(1);

    // Input synchroniser latency: stable before edge N, read at N+1 is old, at N+2 is new
    @(negedge clock);
    pins_in = 8'hA5;
    rd(A_IN, 32'h00000000);
    rd(A_IN, 32'h000000A5);
    @(negedge clock);
    pins_in = 8'h00;
    idle(4);

    // Interrupt: rising edge on enabled pin 0
    wr(A_IEN, 32'h00000001);
    @(negedge clock);
    pins_in = 8'h01;
    @(posedge clock); #1;
    chk("irq_edge_n",  {31'b0, irq}, 32'h0);
    @(posedge clock); #1;
    chk("irq_edge_n1", {31'b0, irq}, 32'h0);
    @(posedge clock); #1;
    chk("irq_edge_n2", {31'b0, irq}, 32'h1);
    @(negedge clock);
    pins_in = 8'h03;
    idle(4);
    rd(A_PEND, 32'h00000001);
    rd(A_IN,   32'h00000003);
    wr(A_PEND, 32'h00000001);
    chk("irq_after_w1c", {31'b0, irq}, 32'h0);
    rd(A_PEND, 32'h00000000);

    // Set wins over W1C: re-arm PEND[0], then clear it in the cycle a new rise is seen
    @(negedge clock);
    pins_in = 8'h02;
    idle(4);
    @(negedge clock);
    pins_in = 8'h03;
    idle(3);
    chk("irq_rearmed", {31'b0, irq}, 32'h1);
    @(negedge clock);
    pins_in = 8'h02;
    idle(4);
    chk("irq_held", {31'b0, irq}, 32'h1);
    @(negedge clock);
    pins_in = 8'h03;
    @(posedge clock);
    @(posedge clock);
    wr(A_PEND, 32'h00000001);
    chk("irq_set_wins", {31'b0, irq}, 32'h1);
    rd(A_PEND, 32'h00000001);

    // Clearing IEN keeps PEND but masks irq
    wr(A_IEN, 32'h00000000);
    chk("irq_ien_off", {31'b0, irq}, 32'h0);
    rd(A_PEND, 32'h00000001);

    idle(3);
    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
